// File: rtl/dht11_responder.sv
// DHT11-style sensor responder: detects a host start pulse on an open-drain line and
// answers with the response preamble, 40 data bits (4 bytes + checksum) and an end pulse.
module dht11_responder #(
  parameter int unsigned CLK_PER_US   = 1,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned WAIT_US      = 30,
  parameter int unsigned RESP_LOW_US  = 80,
  parameter int unsigned RESP_HIGH_US = 80,
  parameter int unsigned BIT_LOW_US   = 50,
  parameter int unsigned ZERO_HIGH_US = 26,
  parameter int unsigned ONE_HIGH_US  = 70,
  parameter int unsigned END_LOW_US   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_in,
  output logic       line_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       done,
  output logic       abort
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned StartMinCyc  = START_MIN_US * CLK_PER_US;
  localparam int unsigned WaitCyc      = WAIT_US * CLK_PER_US;
  localparam int unsigned RespLowCyc   = RESP_LOW_US * CLK_PER_US;
  localparam int unsigned RespHighCyc  = RESP_HIGH_US * CLK_PER_US;
  localparam int unsigned BitLowCyc    = BIT_LOW_US * CLK_PER_US;
  localparam int unsigned ZeroHighCyc  = ZERO_HIGH_US * CLK_PER_US;
  localparam int unsigned OneHighCyc   = ONE_HIGH_US * CLK_PER_US;
  localparam int unsigned EndLowCyc    = END_LOW_US * CLK_PER_US;

  localparam int unsigned MaxCyc = max_u(max_u(max_u(StartMinCyc, WaitCyc),
                                               max_u(RespLowCyc, RespHighCyc)),
                                         max_u(max_u(BitLowCyc, ZeroHighCyc),
                                               max_u(OneHighCyc, EndLowCyc)));
  // One spare bit keeps the saturated START_LOW count strictly above the threshold.
  localparam int unsigned CntW = $clog2(MaxCyc + 1) + 1;

  localparam logic [CntW-1:0] CntMax      = '1;
  localparam logic [CntW-1:0] StartMin    = CntW'(StartMinCyc);
  localparam logic [CntW-1:0] WaitEnd     = CntW'(WaitCyc - 1);
  localparam logic [CntW-1:0] RespLowEnd  = CntW'(RespLowCyc - 1);
  localparam logic [CntW-1:0] RespHighEnd = CntW'(RespHighCyc - 1);
  localparam logic [CntW-1:0] BitLowEnd   = CntW'(BitLowCyc - 1);
  localparam logic [CntW-1:0] ZeroHighEnd = CntW'(ZeroHighCyc - 1);
  localparam logic [CntW-1:0] OneHighEnd  = CntW'(OneHighCyc - 1);
  localparam logic [CntW-1:0] EndLowEnd   = CntW'(EndLowCyc - 1);
  localparam logic [CntW-1:0] SyncSkip    = CntW'(2);
  localparam logic [5:0]      LastBit     = 6'd39;

  typedef enum logic [2:0] {
    StIdle,
    StStartLow,
    StWaitRel,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StEndLow
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [39:0]     shreg_q, shreg_d;
  logic [5:0]      bit_q, bit_d;
  logic            low_q, low_d;
  logic            sync1_q, sync2_q, line_s;
  logic            line_oe_q, line_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic [7:0]      checksum;
  logic            host_pull;
  logic [CntW-1:0] high_end;

  assign line_s   = sync2_q;
  assign cnt_inc  = cnt_q + CntW'(1);
  assign checksum = hum_int + hum_dec + temp_int + temp_dec;
  assign high_end = shreg_q[39] ? OneHighEnd : ZeroHighEnd;
  // The first two cycles of a released phase still show our own pull through the synchronizer.
  assign host_pull = (cnt_q >= SyncSkip) && !line_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    low_d   = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!line_s) begin
          state_d = StStartLow;
        end
      end
      StStartLow: begin
        if (!line_s) begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_inc;
        end else if (cnt_q >= StartMin) begin
          // The cycle that sees the release counts as the first wait cycle.
          state_d = StWaitRel;
          cnt_d   = CntW'(1);
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StWaitRel: begin
        if (!line_s) begin
          state_d = StStartLow;
          cnt_d   = '0;
        end else if (cnt_q >= WaitEnd) begin
          state_d = StRespLow;
          cnt_d   = '0;
          shreg_d = {hum_int, hum_dec, temp_int, temp_dec, checksum};
          bit_d   = '0;
        end
      end
      StRespLow: begin
        if (cnt_q == RespLowEnd) begin
          state_d = StRespHigh;
          cnt_d   = '0;
        end
      end
      StRespHigh: begin
        low_d = host_pull;
        if (host_pull && low_q) begin
          state_d = StIdle;
          cnt_d   = '0;
          low_d   = 1'b0;
          abort_d = 1'b1;
        end else if (cnt_q == RespHighEnd) begin
          state_d = StBitLow;
          cnt_d   = '0;
          low_d   = 1'b0;
        end
      end
      StBitLow: begin
        if (cnt_q == BitLowEnd) begin
          state_d = StBitHigh;
          cnt_d   = '0;
        end
      end
      StBitHigh: begin
        low_d = host_pull;
        if (host_pull && low_q) begin
          state_d = StIdle;
          cnt_d   = '0;
          low_d   = 1'b0;
          abort_d = 1'b1;
        end else if (cnt_q == high_end) begin
          cnt_d   = '0;
          low_d   = 1'b0;
          shreg_d = {shreg_q[38:0], 1'b0};
          if (bit_q == LastBit) begin
            state_d = StEndLow;
          end else begin
            state_d = StBitLow;
            bit_d   = bit_q + 6'd1;
          end
        end
      end
      StEndLow: begin
        if (cnt_q == EndLowEnd) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch exactly on phase boundaries.
  always_comb begin
    line_oe_d = (state_d == StRespLow) || (state_d == StBitLow) || (state_d == StEndLow);
    busy_d    = (state_d == StRespLow) || (state_d == StRespHigh) || (state_d == StBitLow) ||
                (state_d == StBitHigh) || (state_d == StEndLow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      low_q     <= 1'b0;
      line_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      low_q     <= low_d;
      line_oe_q <= line_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign line_oe = line_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: models the open-drain bus and a host, records line_oe phase
// widths and checks them against a frame built from the byte values.
module tb_dht11_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_low = 1'b0;
  logic       line_in;
  logic       line_oe;
  logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
  logic       busy, done, abort;

  // Wired-AND bus with external pull-up.
  assign line_in = ~(host_low | line_oe);

  dht11_responder #(
    .CLK_PER_US  (1),
    .START_MIN_US(100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .line_in (line_in),
    .line_oe (line_oe),
    .hum_int (hum_int),
    .hum_dec (hum_dec),
    .temp_int(temp_int),
    .temp_dec(temp_dec),
    .busy    (busy),
    .done    (done),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lvl;
    logic [31:0] w;
  } seg_t;

  typedef struct {
    string      name;
    logic [7:0] b0, b1, b2, b3;
    int unsigned low_w;
    bit         frame;
  } vec_t;

  int   comps = 0;
  int   fails = 0;
  int   cyc = 0;

  // Monitor state
  logic        mon_clr = 1'b0;
  logic        prev_oe = 1'b0;
  logic        started = 1'b0;
  int unsigned run = 0;
  int unsigned busy_cnt = 0, done_cnt = 0, abort_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int          first_rise = -1;
  seg_t        obs_q[$];

  // Model outputs
  seg_t        exp_q[$];
  logic [39:0] exp_bits;
  int unsigned exp_busy;

  vec_t        vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst || mon_clr) begin
      prev_oe    <= line_oe;
      run        <= 1;
      started    <= 1'b0;
      busy_cnt   <= 0;
      done_cnt   <= 0;
      abort_cnt  <= 0;
      rise_cnt   <= 0;
      fall_cnt   <= 0;
      first_rise <= -1;
      obs_q.delete();
    end else begin
      if (busy)  busy_cnt  <= busy_cnt + 1;
      if (done)  done_cnt  <= done_cnt + 1;
      if (abort) abort_cnt <= abort_cnt + 1;
      if (line_oe != prev_oe) begin
        if (line_oe) begin
          rise_cnt <= rise_cnt + 1;
          if (started) obs_q.push_back('{1'b0, run});
          else         first_rise <= cyc;
          started <= 1'b1;
        end else begin
          fall_cnt <= fall_cnt + 1;
          obs_q.push_back('{1'b1, run});
        end
        run <= 1;
      end else begin
        run <= run + 1;
      end
      prev_oe <= line_oe;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    comps++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    @(posedge clk);
    #1 mon_clr = 1'b1;
    @(posedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // Reference frame: phase list and total busy time from the byte values alone.
  function automatic void build_model(input logic [7:0] b0, b1, b2, b3);
    int unsigned sum;
    sum = b0 + b1 + b2 + b3;
    exp_bits = {b0, b1, b2, b3, 8'(sum % 256)};
    exp_q.delete();
    exp_q.push_back('{1'b1, 32'd80});
    exp_q.push_back('{1'b0, 32'd80});
    exp_busy = 80 + 80 + 50;
    for (int i = 39; i >= 0; i--) begin
      exp_q.push_back('{1'b1, 32'd50});
      exp_q.push_back('{1'b0, exp_bits[i] ? 32'd70 : 32'd26});
      exp_busy += 50 + (exp_bits[i] ? 70 : 26);
    end
    exp_q.push_back('{1'b1, 32'd50});
  endfunction

  task automatic host_start(input int unsigned low_w, output int rel);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (low_w) @(posedge clk);
    #1 host_low = 1'b0;
    rel = cyc;
  endtask

  task automatic run_frame(input string name, input logic [7:0] b0, b1, b2, b3,
                           input int unsigned low_w, input bit expect_frame, input bit mutate);
    int          rel;
    int          mis;
    logic [39:0] got_bits;
    hum_int  = b0;
    hum_dec  = b1;
    temp_int = b2;
    temp_dec = b3;
    mon_clear();
    host_start(low_w, rel);
    if (expect_frame) begin
      for (int i = 0; i < 6000 && done_cnt == 0 && abort_cnt == 0; i++) begin
        @(posedge clk);
        if (mutate && first_rise >= 0) hum_int = 8'hFF;
      end
      repeat (5) @(posedge clk);
      build_model(b0, b1, b2, b3);
      check({name, " done"}, done_cnt, 1);
      check({name, " abort"}, abort_cnt, 0);
      // line_s trails line_in by two edges; response starts 30 cycles after line_s rises.
      check({name, " latency"}, first_rise - rel, 32);
      check({name, " busy"}, busy_cnt, exp_busy);
      mis = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (mis < 0 && (i >= obs_q.size() || obs_q[i] != exp_q[i])) mis = i;
      end
      if (mis < 0) begin
        check({name, " seg count"}, obs_q.size(), exp_q.size());
      end else begin
        check($sformatf("%s seg %0d lvl/width", name, mis),
              (mis < obs_q.size()) ? longint'(obs_q[mis]) : -1, longint'(exp_q[mis]));
      end
      got_bits = '0;
      for (int i = 0; i < 40; i++) begin
        if (3 + 2 * i < obs_q.size()) got_bits[39-i] = (obs_q[3+2*i].w > 48);
      end
      check({name, " content"}, got_bits, exp_bits);
      check({name, " checksum"}, got_bits[7:0], exp_bits[7:0]);
    end else begin
      repeat (300) @(posedge clk);
      check({name, " no drive"}, rise_cnt, 0);
      check({name, " no busy"}, busy_cnt, 0);
      check({name, " no abort"}, abort_cnt, 0);
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic add_vec(input string name, input logic [7:0] b0, b1, b2, b3,
                         input int unsigned low_w, input bit frame);
    vec_t v;
    v.name = name; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.low_w = low_w; v.frame = frame;
    vecs.push_back(v);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          rel;
    logic [7:0]  r0, r1, r2, r3;

    #1 rst = 1'b1;
    #1;
    check("reset line_oe", line_oe, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset abort", abort, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    add_vec("basic",  8'h37, 8'h00, 8'h19, 8'h00, 150, 1'b1);
    add_vec("zeros",  8'h00, 8'h00, 8'h00, 8'h00, 150, 1'b1);
    add_vec("runt60", 8'h37, 8'h00, 8'h19, 8'h00, 60,  1'b0);
    add_vec("ones",   8'hFF, 8'hFF, 8'hFF, 8'hFF, 120, 1'b1);
    add_vec("runt95", 8'h12, 8'h34, 8'h56, 8'h78, 95,  1'b0);
    add_vec("w110",   8'hA5, 8'h5A, 8'hC3, 8'h3C, 110, 1'b1);
    foreach (vecs[i]) begin
      run_frame(vecs[i].name, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3,
                vecs[i].low_w, vecs[i].frame, 1'b0);
    end

    for (int k = 0; k < 4; k++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      run_frame($sformatf("rand%0d", k), r0, r1, r2, r3, $urandom_range(110, 250), 1'b1, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      run_frame($sformatf("rrunt%0d", k), 8'h55, 8'h66, 8'h77, 8'h88,
                $urandom_range(5, 90), 1'b0, 1'b0);
    end

    // Snapshot: hum_int changes after the response has started.
    run_frame("snapshot", 8'h37, 8'h00, 8'h19, 8'h00, 150, 1'b1, 1'b1);

    // Host collision 10 cycles into the fifth data-bit high phase.
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
    mon_clear();
    host_start(150, rel);
    for (int i = 0; i < 2000 && fall_cnt < 6; i++) @(posedge clk);
    check("abort reach bit5", fall_cnt, 6);
    repeat (9) @(posedge clk);
    #1 host_low = 1'b1;
    repeat (5) @(posedge clk);
    #1 host_low = 1'b0;
    for (int i = 0; i < 100 && abort_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("abort pulse", abort_cnt, 1);
    check("abort no done", done_cnt, 0);
    check("abort line_oe", line_oe, 0);
    check("abort busy", busy, 0);
    repeat (20) @(posedge clk);
    run_frame("after abort", 8'h37, 8'h00, 8'h19, 8'h00, 150, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the second bit-low phase.
    mon_clear();
    host_start(150, rel);
    for (int i = 0; i < 2000 && rise_cnt < 3; i++) @(posedge clk);
    check("rst reach bitlow", rise_cnt, 3);
    #3;
    check("rst pre line_oe", line_oe, 1);
    rst = 1'b1;
    #1;
    check("rst async line_oe", line_oe, 0);
    check("rst async busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_clear();
    repeat (300) @(posedge clk);
    #1;
    check("post rst no drive", rise_cnt, 0);
    check("post rst no busy", busy_cnt, 0);
    check("post rst no done", done_cnt, 0);
    check("post rst no abort", abort_cnt, 0);
    check("post rst line_oe", line_oe, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 1: clk cycles per microsecond.
REQ-002 SHALL have parameter START_MIN_US, default 18000: minimum host start-low width accepted.
REQ-003 SHALL have parameter WAIT_US, default 30: delay from host release to response.
REQ-004 SHALL have parameters RESP_LOW_US 80, RESP_HIGH_US 80, BIT_LOW_US 50, ZERO_HIGH_US 26, ONE_HIGH_US 70, END_LOW_US 50: the phase widths.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port line_in  input  1  sampled level of the shared 1-wire data line (pulled up externally).
REQ-008 SHALL have port line_oe  output  1  1 = pull line low (open-drain), 0 = release.
REQ-009 SHALL have ports hum_int, hum_dec, temp_int, temp_dec  input  8 each  measurement bytes to report.
REQ-010 SHALL have port busy  output  1  high from response start through end of frame.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal frame completion.
REQ-012 SHALL have port abort  output  1  one-cycle pulse when a frame is abandoned.

Function
REQ-013 SHALL pass line_in through a 2-flop synchronizer; all decisions use the synchronized level (line_s).
REQ-014 SHALL implement states IDLE, START_LOW, WAIT_REL, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-015 IDLE: line_oe=0; line_s=0 -> START_LOW with width counter cleared.
REQ-016 START_LOW: count cycles while line_s=0 (saturating); on line_s=1 go WAIT_REL if count >= START_MIN_US*CLK_PER_US, else IDLE (runt ignored, no abort).
REQ-017 WAIT_REL: after exactly WAIT_US*CLK_PER_US cycles -> RESP_LOW; line_s=0 during WAIT_REL -> START_LOW (restart measurement).
REQ-018 On entering RESP_LOW SHALL snapshot the four input bytes and checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256 into a 40-bit shift register; input changes afterwards do not affect the frame.
REQ-019 Each driven phase SHALL last exactly its parameter times CLK_PER_US cycles: line_oe=1 in RESP_LOW, BIT_LOW, END_LOW; line_oe=0 in RESP_HIGH, BIT_HIGH.
REQ-020 Bit order: hum_int, hum_dec, temp_int, temp_dec, checksum; MSB first within each byte.
REQ-021 BIT_HIGH width SHALL be ONE_HIGH_US for a 1 bit, ZERO_HIGH_US for a 0 bit; after bit 40 -> END_LOW, otherwise -> BIT_LOW.
REQ-022 END_LOW completion -> IDLE with line_oe=0 and done=1 for one cycle.
REQ-023 line_oe SHALL be registered (glitch-free) and change only on phase boundaries.
REQ-024 busy=1 in RESP_LOW through END_LOW inclusive, 0 otherwise.
REQ-025 In RESP_HIGH or BIT_HIGH, line_s=0 for 2 consecutive cycles beyond the first 2 cycles of the phase (synchronizer latency of own release) SHALL abort: line_oe=0, abort=1 for one cycle, -> IDLE; done not pulsed.
REQ-026 A new host start SHALL only be recognized from IDLE; the line is not monitored for starts while busy.
REQ-027 Counters SHALL be wide enough for START_MIN_US*CLK_PER_US without wrap; the START_LOW counter saturates.

Reset
REQ-028 rst=1 SHALL immediately force line_oe=0, busy=0, done=0, abort=0, state IDLE, counters and shift register to 0, synchronizer flops to 1.
REQ-029 Reset asserted mid-frame SHALL release the line in the same instant; after deassertion no partial frame resumes.

Verification (CLK_PER_US=1, START_MIN_US=100)
REQ-030 Host low 150 us, release; bytes 0x37,0x00,0x19,0x00 -> line_oe rises 30 us after line_s rises, checksum bits decode as 0x50, done pulses once, all widths exact.
REQ-031 All-zero bytes -> total busy time exactly 80+80+40*(50+26)+50 = 3250 cycles; all BIT_HIGH phases 26 cycles.
REQ-032 Host low 60 us (runt) -> no line_oe assertion, busy stays 0, no abort.
REQ-033 Host pulls line low 10 cycles into the 5th BIT_HIGH -> abort pulse, line_oe=0, returns IDLE; next valid start yields a full correct frame.
REQ-034 rst asserted during BIT_LOW -> line_oe=0 asynchronously; after release, IDLE with all outputs 0.
REQ-035 Change hum_int from 0x37 to 0xFF during the frame -> transmitted frame still carries 0x37 and checksum 0x50.
